key_expand: RTL and testbench

Iterative AES-128 key schedule. It sits directly upstream of the round-key XOR stage and drives that stage's key input with round keys 0 through 10, one per cycle. It loads a 128-bit cipher key on a start pulse and produces one round key per advancing cycle. Keys are tagged with a round index and a valid strobe so the datapath controller can pair each key with the matching state word.

---
 rtl/key_expand_if.sv | 22 ++
 rtl/key_expand.sv | 108 ++++++++++
 tb/tb_key_expand.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/key_expand_if.sv
// Handshake bundle between the key-schedule controller and key_expand.
// The master drives requests and key material; the slave returns tagged round keys.
interface key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic         hold;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, hold,
    input  round_key, round_num, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, hold,
    output round_key, round_num, key_valid, busy, done
  );
endinterface

// File: rtl/key_expand.sv
// Iterative AES-128 key schedule: one round key (0..10) per advancing cycle,
// tagged with its round index, stallable with hold.
module key_expand (
  input  logic         CLK,
  input  logic         RST,
  key_expand_if.slave  kx
);

  typedef enum logic {IDLE, RUN} state_t;

  // Forward S-box; entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t       state;
  logic [7:0]   rcon;
  logic [127:0] round_key_q;
  logic [3:0]   round_num_q;
  logic         key_valid_q;
  logic         busy_q;
  logic         done_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_next;

  assign w0 = round_key_q[127:96];
  assign w1 = round_key_q[95:64];
  assign w2 = round_key_q[63:32];
  assign w3 = round_key_q[31:0];

  assign n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // Controller; hold only matters once an expansion is running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      rcon        <= 8'h00;
      round_key_q <= 128'h0;
      round_num_q <= 4'd0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (kx.start) begin
            state       <= RUN;
            rcon        <= 8'h01;
            round_key_q <= kx.key_in;
            round_num_q <= 4'd0;
            key_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        RUN: begin
          if (!kx.hold) begin
            if (round_num_q == 4'd10) begin
              state       <= IDLE;
              key_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b0;
            end else begin
              round_key_q <= {n0, n1, n2, n3};
              round_num_q <= round_num_q + 4'd1;
              rcon        <= rcon_next;
              done_q      <= (round_num_q == 4'd9);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kx.round_key = round_key_q;
  assign kx.round_num = round_num_q;
  assign kx.key_valid = key_valid_q;
  assign kx.busy      = busy_q;
  assign kx.done      = done_q;

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: FIPS-197 vectors, hold, restart, reset
// and random keys against a GF(2^8)-derived key-schedule model.
module tb_key_expand;

  logic CLK = 1'b0;
  logic RST;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] ks  [11];
  logic [127:0] obs [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_expand_if kx ();

  key_expand dut (
    .CLK (CLK),
    .RST (RST),
    .kx  (kx)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic compute_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) ks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    checkOutput({tag, " round_key"}, kx.round_key, 128'h0);
    checkOutput({tag, " round_num"}, 128'(kx.round_num), 128'h0);
    checkOutput({tag, " key_valid"}, 128'(kx.key_valid), 128'h0);
    checkOutput({tag, " busy"}, 128'(kx.busy), 128'h0);
    checkOutput({tag, " done"}, 128'(kx.done), 128'h0);
  endtask

  function automatic logic [127:0] random128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start an expansion and follow it to the idle cycle after round 10.
  task automatic applyStimulus(input logic [127:0] key, input string name,
                               input int hold_round, input int hold_len,
                               input int restart_round, input int reset_round,
                               input logic start_hold);
    int   r, holds_left, valid_cycles, guard;
    bit   finished, restarted;
    logic held;
    compute_schedule(key);
    kx.key_in = key;
    kx.start  = 1'b1;
    kx.hold   = start_hold;
    step();
    kx.start  = 1'b0;
    kx.hold   = 1'b0;
    kx.key_in = random128();
    r = 0; holds_left = hold_len; valid_cycles = 0; guard = 0;
    finished = 0; restarted = 0;
    while (!finished) begin
      checkOutput({name, " round_key"}, kx.round_key, ks[r]);
      checkOutput({name, " round_num"}, 128'(kx.round_num), 128'(r));
      checkOutput({name, " key_valid"}, 128'(kx.key_valid), 128'h1);
      checkOutput({name, " busy"}, 128'(kx.busy), 128'h1);
      checkOutput({name, " done"}, 128'(kx.done), 128'(r == 10));
      obs[r] = kx.round_key;
      valid_cycles += int'(kx.key_valid);
      if (r == reset_round) begin
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_idle_zero({name, " after reset"});
        return;
      end
      held = (r == hold_round && holds_left > 0);
      if (held) holds_left--;
      kx.hold = held;
      if (r == restart_round && !restarted && !held) begin
        kx.start  = 1'b1;
        kx.key_in = ~key;
        restarted = 1;
      end
      step();
      kx.start = 1'b0;
      kx.hold  = 1'b0;
      if (!held) begin
        if (r == 10) finished = 1;
        else r++;
      end
      guard++;
      if (guard > 40) begin
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL %s timeout observed=%0d cycles expected<=40", name, guard);
        return;
      end
    end
    checkOutput({name, " end busy"}, 128'(kx.busy), 128'h0);
    checkOutput({name, " end key_valid"}, 128'(kx.key_valid), 128'h0);
    checkOutput({name, " end done"}, 128'(kx.done), 128'h0);
    checkOutput({name, " end round_num"}, 128'(kx.round_num), 128'd10);
    checkOutput({name, " end round_key"}, kx.round_key, ks[10]);
    checkOutput({name, " valid cycles"}, 128'(valid_cycles), 128'(11 + hold_len));
  endtask

  initial begin
    RST       = 1'b1;
    kx.start  = 1'b0;
    kx.hold   = 1'b0;
    kx.key_in = 128'h0;
    build_sbox();
    repeat (2) step();
    check_idle_zero("reset");
    RST = 1'b0;
    kx.hold = 1'b1;
    step();
    check_idle_zero("idle");
    kx.hold = 1'b0;

    applyStimulus(FIPS_KEY, "fips", -1, 0, -1, -1, 1'b0);
    checkOutput("fips r0 const", obs[0], FIPS_KEY);
    checkOutput("fips r1 const", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
    checkOutput("fips r10 const", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    step();
    applyStimulus(128'h0, "zero", -1, 0, -1, -1, 1'b0);
    checkOutput("zero r1 const", obs[1], 128'h62636363626363636263636362636363);
    checkOutput("zero r10 const", obs[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    applyStimulus(FIPS_KEY, "hold4", 4, 3, -1, -1, 1'b0);
    checkOutput("hold4 r10 const", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    applyStimulus(random128(), "busy_start", -1, 0, 5, -1, 1'b0);
    applyStimulus(random128(), "late_start", -1, 0, 10, -1, 1'b0);

    applyStimulus(random128(), "reset6", -1, 0, -1, 6, 1'b0);
    applyStimulus(FIPS_KEY, "after_reset", -1, 0, -1, -1, 1'b0);
    applyStimulus(128'h0, "back2back", -1, 0, -1, -1, 1'b0);
    checkOutput("back2back r1 const", obs[1], 128'h62636363626363636263636362636363);

    applyStimulus(random128(), "idle_hold_start", -1, 0, -1, -1, 1'b1);

    for (int n = 0; n < 8; n++) begin
      applyStimulus(random128(), $sformatf("rand%0d", n), int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 3)), -1, -1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
